div_iter: RTL and testbench
===========================

# div_iter

Iterative 32-bit radix-2 divider for the execute stage, serving DIV and DIVU after the main decoder has flagged them (aluop = DIV/DIVU, write_hilo = 1). It accepts one operation at a time and computes quotient and remainder in 32 iteration cycles. It holds the pipeline stall line high while it works, then presents a 64-bit {HI, LO} result for exactly one cycle, to be written into HILO. Flush or exception cancel aborts an operation in flight.

## Interface
- WIDTH, 32, operand width; only 32 is supported.
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  E-stage instruction is DIV/DIVU, already qualified by the E-stage valid signal.
- signed_div  in  1  1 = DIV, 0 = DIVU; sampled with start.
- cancel  in  1  E-stage flush or exception; aborts any operation.
- a  in  32  dividend (rs), sampled with start.
- b  in  32  divisor (rt), sampled with start.
- stall  out  1  request to the hazard unit to freeze F/D/E.
- valid  out  1  result valid, one-cycle pulse.
- result  out  64  {HI = remainder, LO = quotient}.

## Operation
- States:
  - IDLE: waiting for an operation.
  - BUSY: iterating.
  - DONE: result presented.
- IDLE → BUSY on start & ~cancel & b≠0.
  - Captures |a| and |b| (magnitudes only when signed_div; raw values otherwise).
  - Captures sign_q = signed_div & (a[31]^b[31]) and sign_r = signed_div & a[31].
  - Clears the iteration counter to 0.
- IDLE → DONE on start & ~cancel & b==0.
  - Result is forced to {a, 32'hFFFF_FFFF}, with no sign fixup.
- BUSY performs one restoring step per cycle:
  - Shift the 65-bit partial remainder/quotient register {r[32:0], q[31:0]} left by 1.
  - Trial = r − {1'b0, |b|}. If trial ≥ 0, set r = trial and q[0] = 1.
  - Counter increments each step; BUSY → DONE after the step where counter == 31 (32 steps in total).
- DONE:
  - Registers result: LO = sign_q ? −q : q, HI = sign_r ? −r : r.
  - Asserts valid for one cycle, then DONE → IDLE unconditionally.
- stall = (IDLE & start & ~cancel) | BUSY. It is combinational from state and inputs, and deasserted in DONE so the instruction advances together with valid.
- cancel in any state: next state is IDLE, valid stays 0, and result holds its previous value.
- start in BUSY or DONE is ignored. The pipeline is frozen, so a second divide cannot legitimately arrive.
- Overflow case 0x8000_0000 / 0xFFFF_FFFF (signed) yields LO = 0x8000_0000, HI = 0, with no trap.
- Width rules:
  - Magnitudes are 32-bit unsigned, so |−2^31| = 0x8000_0000 is representable.
  - The remainder register is 33 bits, so the trial subtraction needs no extra carry logic.

## Timing
- Reset values: state IDLE, valid 0, result 0, stall 0. rst has priority over start and cancel in the same cycle.
- Latency, start accepted in cycle 0:
  - BUSY covers cycles 1–32.
  - DONE is cycle 33: valid = 1, stall = 0.
  - stall is high in cycles 0–32 (33 cycles).
- Divide-by-zero: DONE in cycle 1, stall high in cycle 0 only.
- Back-to-back divides: the earliest new start is in the cycle after DONE, i.e. one idle cycle minimum between results.
- rst asserted mid-BUSY: IDLE next edge, no valid pulse.

## Structure
- State encoding and the DIV_STEPS = 32 constant go in the shared defines header, beside the existing EXE_DIV_OP / EXE_DIVU_OP aluop codes. The instantiating E stage derives start from those codes.
- One combinational sub-module, div_step, computes a single shift-subtract iteration: 65-bit in → 65-bit out, with |b| as an input. div_iter holds only the FSM, counter, operand/sign registers and the output fixup.

## Test plan
- DIVU a=100, b=7, start one cycle → stall high 33 cycles; valid in cycle 33 with result = {32'd2, 32'd14}.
- DIV a=−7 (0xFFFF_FFF9), b=2 → LO = 0xFFFF_FFFD (−3), HI = 0xFFFF_FFFF (−1).
- DIV a=0x8000_0000, b=0xFFFF_FFFF → LO = 0x8000_0000, HI = 0; DIVU with the same operands → LO = 0, HI = 0x8000_0000.
- DIV a=5, b=0 → valid in cycle 1, result = {0x0000_0005, 0xFFFF_FFFF}, stall high only in cycle 0.
- Start DIVU 1000/3, assert cancel in cycle 10 → IDLE in cycle 11, no valid ever. A new DIVU 9/3 started in cycle 12 → valid in cycle 45 with result {0, 3}.
- Assert rst in cycle 20 of a busy operation → stall 0 and valid 0 from the next cycle, result = 0.

Source files
------------

// File: rtl/div_iter_pkg.sv
// Shared definitions for the iterative divider:
// FSM encoding, iteration count, E-stage aluop codes.
package div_iter_pkg;

  localparam int WIDTH     = 32;
  localparam int DIV_STEPS = 32;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  function automatic logic [WIDTH-1:0] neg_if(
    input logic             s,
    input logic [WIDTH-1:0] v
  );
    return s ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle between the E stage
// and the divider.
interface div_iter_if
  import div_iter_pkg::*;
();

  logic               start;
  logic               signed_div;
  logic               cancel;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               stall;
  logic               valid;
  logic [2*WIDTH-1:0] result;

  modport master (
    output start, signed_div, cancel, a, b,
    input  stall, valid, result
  );

  modport slave (
    input  start, signed_div, cancel, a, b,
    output stall, valid, result
  );

endinterface

// File: rtl/div_step.sv
// One restoring shift-subtract iteration over the
// {r[32:0], q[31:0]} register.
module div_step
  import div_iter_pkg::*;
(
  input  logic [2*WIDTH:0]   acc,
  input  logic [WIDTH-1:0]   dvs,
  output logic [2*WIDTH:0]   acc_n
);

  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] trial;

  // one spare top bit keeps the trial sign unambiguous
  assign r_sh  = {acc[2*WIDTH:WIDTH-1]};
  assign trial = r_sh - {2'b00, dvs};

  always_comb begin
    if (trial[WIDTH+1]) begin
      acc_n = {r_sh[WIDTH:0], acc[WIDTH-2:0], 1'b0};
    end else begin
      acc_n = {trial[WIDTH:0], acc[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/div_iter.sv
// Iterative radix-2 DIV/DIVU unit: FSM, counter,
// operand/sign registers and sign fixup of {HI, LO}.
module div_iter
  import div_iter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  div_iter_if.slave  bus
);

  state_t           state;
  state_t           state_n;
  logic [2*WIDTH:0] acc;
  logic [2*WIDTH:0] acc_n;
  logic [WIDTH-1:0] dvs;
  logic [4:0]       cnt;
  logic             sign_q;
  logic             sign_r;
  logic             go;
  logic             last;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  div_step u_step (
    .acc   (acc),
    .dvs   (dvs),
    .acc_n (acc_n)
  );

  assign go    = bus.start & ~bus.cancel;
  assign last  = (cnt == 5'(DIV_STEPS - 1));
  assign mag_a = neg_if(bus.signed_div & bus.a[WIDTH-1], bus.a);
  assign mag_b = neg_if(bus.signed_div & bus.b[WIDTH-1], bus.b);

  always_comb begin
    state_n   = state;
    bus.stall = 1'b0;
    bus.valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        bus.stall = go;
        if (go) begin
          state_n = (bus.b == '0) ? S_DONE : S_BUSY;
        end
      end
      S_BUSY: begin
        bus.stall = 1'b1;
        if (last) state_n = S_DONE;
      end
      S_DONE: begin
        bus.valid = ~bus.cancel;
        state_n   = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (bus.cancel) state_n = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      acc        <= '0;
      dvs        <= '0;
      cnt        <= '0;
      sign_q     <= 1'b0;
      sign_r     <= 1'b0;
      bus.result <= '0;
    end else begin
      state <= state_n;
      if (state == S_IDLE && go) begin
        if (bus.b == '0) begin
          bus.result <= {bus.a, {WIDTH{1'b1}}};
        end else begin
          acc    <= {{(WIDTH+1){1'b0}}, mag_a};
          dvs    <= mag_b;
          cnt    <= '0;
          sign_q <= bus.signed_div
                    & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          sign_r <= bus.signed_div & bus.a[WIDTH-1];
        end
      end
      if (state == S_BUSY && !bus.cancel) begin
        acc <= acc_n;
        cnt <= cnt + 5'd1;
        // result lands as DONE is entered so valid sees it
        if (last) begin
          bus.result <= {
            neg_if(sign_r, acc_n[2*WIDTH-1:WIDTH]),
            neg_if(sign_q, acc_n[WIDTH-1:0])
          };
        end
      end
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, stall window,
// signed/unsigned results, div-by-zero, cancel, reset.
module tb_div_iter;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  div_iter_if bus ();

  div_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.start      = 1'b0;
    bus.signed_div = 1'b0;
    bus.cancel     = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_stall got=%b exp=0", bus.stall);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_valid got=%b exp=0", bus.valid);
    end
    checks++;
    if (bus.result !== 64'd0) begin
      failures++;
      $display("FAIL reset_result got=%h exp=0", bus.result);
    end
  endtask

  task automatic run_div(
    input string       name,
    input logic        sd,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [63:0] exp_res,
    input int          lat
  );
    int got;
    int stall_n;
    @(negedge clk);
    bus.start      = 1'b1;
    bus.signed_div = sd;
    bus.a          = a;
    bus.b          = b;
    #1;
    checks++;
    if (bus.stall !== 1'b1) begin
      failures++;
      $display("FAIL %s_stall0 got=%b exp=1", name, bus.stall);
    end
    stall_n = 1;
    got     = -1;
    for (int c = 1; c <= 40 && got < 0; c++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (bus.valid === 1'b1) begin
        got = c;
        checks++;
        if (bus.stall !== 1'b0) begin
          failures++;
          $display("FAIL %s_done_stall got=%b exp=0",
                   name, bus.stall);
        end
        checks++;
        if (bus.result !== exp_res) begin
          failures++;
          $display("FAIL %s_result got=%h exp=%h",
                   name, bus.result, exp_res);
        end
      end else if (bus.stall === 1'b1) begin
        stall_n++;
      end
    end
    checks++;
    if (got != lat) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, got, lat);
    end
    checks++;
    if (stall_n != lat) begin
      failures++;
      $display("FAIL %s_stall_cycles got=%0d exp=%0d",
               name, stall_n, lat);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_pulse got=%b exp=0", name, bus.valid);
    end
  endtask

  task automatic test_unsigned();
    run_div("divu_100_7", 1'b0, 32'd100, 32'd7,
            {32'd2, 32'd14}, 33);
    run_div("divu_min_m1", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF,
            {32'h8000_0000, 32'h0000_0000}, 33);
  endtask

  task automatic test_signed();
    run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
            {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
            {32'd1, 32'hFFFF_FFFD}, 33);
    run_div("div_100_m7", 1'b1, 32'd100, 32'hFFFF_FFF9,
            {32'd2, 32'hFFFF_FFF2}, 33);
    run_div("div_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
            {32'h0000_0000, 32'h8000_0000}, 33);
  endtask

  task automatic test_div_zero();
    run_div("div_zero", 1'b1, 32'd5, 32'd0,
            {32'h0000_0005, 32'hFFFF_FFFF}, 1);
  endtask

  task automatic test_cancel();
    int vcnt;
    int got;
    vcnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd1000;
    bus.b     = 32'd3;
    for (int c = 1; c <= 11; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 10) bus.cancel = 1'b1;
      #1;
      if (bus.valid === 1'b1) vcnt++;
      if (c == 11) begin
        checks++;
        if (bus.stall !== 1'b0) begin
          failures++;
          $display("FAIL cancel_idle_stall got=%b exp=0", bus.stall);
        end
      end
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd9;
    bus.b     = 32'd3;
    got       = -1;
    for (int c = 13; c <= 60 && got < 0; c++) begin
      @(negedge clk);
      idle_inputs();
      #1;
      if (bus.valid === 1'b1) begin
        got = c;
        checks++;
        if (bus.result !== {32'd0, 32'd3}) begin
          failures++;
          $display("FAIL cancel_next_result got=%h exp=%h",
                   bus.result, {32'd0, 32'd3});
        end
      end
    end
    checks++;
    if (vcnt != 0) begin
      failures++;
      $display("FAIL cancel_no_valid got=%0d exp=0", vcnt);
    end
    checks++;
    if (got != 45) begin
      failures++;
      $display("FAIL cancel_next_latency got=%0d exp=45", got);
    end
  endtask

  task automatic test_reset_busy();
    int vcnt;
    vcnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      idle_inputs();
      if (c == 20) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (bus.stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy_stall got=%b exp=0", bus.stall);
    end
    checks++;
    if (bus.result !== 64'd0) begin
      failures++;
      $display("FAIL rst_busy_result got=%h exp=0", bus.result);
    end
    for (int c = 0; c < 40; c++) begin
      if (bus.valid === 1'b1) vcnt++;
      @(negedge clk);
      #1;
    end
    checks++;
    if (vcnt != 0) begin
      failures++;
      $display("FAIL rst_busy_no_valid got=%0d exp=0", vcnt);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_cancel();
    test_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
